// File: rtl/demux_stream_nch_if.sv
// Stream bus for demux_stream_nch: one input word stream and NUM_CH
// registered output channels, each with its own valid/ready pair.
interface demux_stream_nch_if #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SEL_WIDTH   = 2
);
  logic [WORD_LENGTH-1:0]        Data_in;
  logic [SEL_WIDTH-1:0]          sel;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_CH*WORD_LENGTH-1:0] Data_out;
  logic [NUM_CH-1:0]             out_valid;
  logic [NUM_CH-1:0]             out_ready;

  // Producer/consumer side.
  modport master (
    output Data_in, sel, in_valid, out_ready,
    input  in_ready, Data_out, out_valid
  );

  // Demux side.
  modport slave (
    input  Data_in, sel, in_valid, out_ready,
    output in_ready, Data_out, out_valid
  );
endinterface

// File: rtl/demux_stream_nch.sv
// Stream demultiplexer: routes one input word stream to NUM_CH one-entry
// output slots with per-channel valid/ready; out-of-range words are counted.
module demux_stream_nch #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned ZERO_IDLE   = 1,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  demux_stream_nch_if.slave    bus,
  input  logic                 clear_drop,
  output logic                 drop_flag,
  output logic [CNT_WIDTH-1:0] drop_count
);

  logic [NUM_CH-1:0]      sel_hot;
  logic [NUM_CH-1:0]      load;
  logic [NUM_CH-1:0]      valid_q;
  logic [WORD_LENGTH-1:0] slot_q [NUM_CH];
  logic                   in_range;
  logic                   ready_int;
  logic                   drop;

  // One-hot select decode; an out-of-range sel decodes to all zeros, which
  // makes in_ready 1 and marks the word as a drop without any wide compare.
  always_comb begin
    sel_hot = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sel_hot[k] = (bus.sel == SEL_WIDTH'(k));
    end
  end

  always_comb begin
    in_range  = |sel_hot;
    ready_int = ~|(sel_hot & valid_q & ~bus.out_ready);
    load      = (bus.in_valid && ready_int) ? sel_hot : '0;
    drop      = bus.in_valid && !in_range;
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        // A load on a draining slot overwrites it and keeps valid high.
        if (load[k]) begin
          slot_q[k]  <= bus.Data_in;
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] && bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_flag  <= 1'b0;
      drop_count <= '0;
    end else if (clear_drop) begin
      drop_flag  <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      drop_flag <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    bus.Data_out = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if ((ZERO_IDLE == 0) || valid_q[k]) begin
        bus.Data_out[k*WORD_LENGTH +: WORD_LENGTH] = slot_q[k];
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_nch.sv
// Directed bench for demux_stream_nch: a 4-channel zero-idle instance (A)
// and a 3-channel hold-last instance (B) with out-of-range select codes.
module tb_demux_stream_nch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_a, clear_b;
  logic       drop_flag_a, drop_flag_b;
  logic [7:0] drop_count_a, drop_count_b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  demux_stream_nch_if #(.WORD_LENGTH(8), .NUM_CH(4), .SEL_WIDTH(2)) ia ();
  demux_stream_nch_if #(.WORD_LENGTH(8), .NUM_CH(3), .SEL_WIDTH(2)) ib ();

  demux_stream_nch #(.WORD_LENGTH(8), .NUM_CH(4), .SEL_WIDTH(2), .ZERO_IDLE(1), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(rst_n), .bus(ia),
    .clear_drop(clear_a), .drop_flag(drop_flag_a), .drop_count(drop_count_a)
  );

  demux_stream_nch #(.WORD_LENGTH(8), .NUM_CH(3), .SEL_WIDTH(2), .ZERO_IDLE(0), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .reset(rst_n), .bus(ib),
    .clear_drop(clear_b), .drop_flag(drop_flag_b), .drop_count(drop_count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ia.Data_in = '0; ia.sel = '0; ia.in_valid = 1'b0; ia.out_ready = '0;
    ib.Data_in = '0; ib.sel = '0; ib.in_valid = 1'b0; ib.out_ready = '0;
    clear_a = 1'b0; clear_b = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (ia.out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid_a: got %b expected %b", ia.out_valid, 4'b0000); end
    checks++; if (ia.Data_out !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h expected %h", ia.Data_out, 32'h0); end
    checks++; if (ib.out_valid !== 3'b000) begin errors++; $display("FAIL reset_valid_b: got %b expected %b", ib.out_valid, 3'b000); end
    checks++; if (ib.Data_out !== 24'h0) begin errors++; $display("FAIL reset_data_b: got %h expected %h", ib.Data_out, 24'h0); end
    checks++; if (drop_flag_b !== 1'b0 || drop_count_b !== 8'd0) begin errors++; $display("FAIL reset_drop_b: got %b/%0d expected 0/0", drop_flag_b, drop_count_b); end
    rst_n = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ia.in_ready); end
  endtask

  task automatic test_basic();
    ia.out_ready = 4'b1111;
    step();
    ia.Data_in = 8'hA5; ia.sel = 2'd2; ia.in_valid = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b expected 1", ia.in_ready); end
    step();
    ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 4'b0100) begin errors++; $display("FAIL basic_valid: got %b expected %b", ia.out_valid, 4'b0100); end
    checks++; if (ia.Data_out !== 32'h00A5_0000) begin errors++; $display("FAIL basic_data: got %h expected %h", ia.Data_out, 32'h00A5_0000); end
    step();
    checks++; if (ia.out_valid !== 4'b0000) begin errors++; $display("FAIL basic_drained: got %b expected %b", ia.out_valid, 4'b0000); end
    checks++; if (ia.Data_out !== 32'h0) begin errors++; $display("FAIL basic_idle_data: got %h expected %h", ia.Data_out, 32'h0); end
  endtask

  task automatic test_back_pressure();
    ia.out_ready = 4'b1101;
    step();
    ia.Data_in = 8'h11; ia.sel = 2'd1; ia.in_valid = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", ia.in_ready); end
    step();
    ia.Data_in = 8'h22; ia.sel = 2'd1;
    #1;
    checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_ready: got %b expected 0", ia.in_ready); end
    step();
    checks++; if (ia.out_valid !== 4'b0010 || ia.Data_out[15:8] !== 8'h11) begin errors++; $display("FAIL bp_hold: got %b/%h expected 0010/11", ia.out_valid, ia.Data_out[15:8]); end
    ia.Data_in = 8'h33; ia.sel = 2'd3;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready: got %b expected 1", ia.in_ready); end
    step();
    checks++; if (ia.out_valid !== 4'b1010 || ia.Data_out !== 32'h3300_1100) begin errors++; $display("FAIL bp_other_load: got %b/%h expected 1010/33001100", ia.out_valid, ia.Data_out); end
    ia.Data_in = 8'h22; ia.sel = 2'd1;
    #1;
    checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_stalled: got %b expected 0", ia.in_ready); end
    step();
    checks++; if (ia.out_valid !== 4'b0010 || ia.Data_out[15:8] !== 8'h11) begin errors++; $display("FAIL bp_other_drain: got %b/%h expected 0010/11", ia.out_valid, ia.Data_out[15:8]); end
    ia.out_ready = 4'b1111;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", ia.in_ready); end
    step();
    ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 4'b0010 || ia.Data_out[15:8] !== 8'h22) begin errors++; $display("FAIL bp_replace: got %b/%h expected 0010/22", ia.out_valid, ia.Data_out[15:8]); end
    step();
    checks++; if (ia.out_valid !== 4'b0000) begin errors++; $display("FAIL bp_final_drain: got %b expected 0000", ia.out_valid); end
  endtask

  task automatic test_back_to_back();
    ia.out_ready = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i > 1) begin
        checks++; if (ia.out_valid !== 4'b0001 || ia.Data_out[7:0] !== 8'(i - 1)) begin errors++; $display("FAIL b2b_word%0d: got %b/%h expected 0001/%h", i - 1, ia.out_valid, ia.Data_out[7:0], 8'(i - 1)); end
      end
      ia.Data_in = 8'(i); ia.sel = 2'd0; ia.in_valid = 1'b1;
      #1;
      checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, ia.in_ready); end
    end
    step();
    ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 4'b0001 || ia.Data_out[7:0] !== 8'h08) begin errors++; $display("FAIL b2b_last: got %b/%h expected 0001/08", ia.out_valid, ia.Data_out[7:0]); end
    step();
    checks++; if (ia.out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain: got %b expected 0000", ia.out_valid); end
  endtask

  task automatic test_drop();
    ib.out_ready = 3'b111;
    step();
    ib.Data_in = 8'h77; ib.sel = 2'd3; ib.in_valid = 1'b1;
    #1;
    checks++; if (ib.in_ready !== 1'b1) begin errors++; $display("FAIL drop_in_ready: got %b expected 1", ib.in_ready); end
    step();
    ib.in_valid = 1'b0;
    checks++; if (ib.out_valid !== 3'b000) begin errors++; $display("FAIL drop_no_valid: got %b expected 000", ib.out_valid); end
    checks++; if (drop_flag_b !== 1'b1 || drop_count_b !== 8'd1) begin errors++; $display("FAIL drop_first: got %b/%0d expected 1/1", drop_flag_b, drop_count_b); end
    ib.in_valid = 1'b1;
    repeat (253) step();
    checks++; if (drop_count_b !== 8'd254) begin errors++; $display("FAIL drop_count_254: got %0d expected 254", drop_count_b); end
    repeat (47) step();
    ib.in_valid = 1'b0;
    checks++; if (drop_count_b !== 8'd255 || drop_flag_b !== 1'b1) begin errors++; $display("FAIL drop_saturate: got %b/%0d expected 1/255", drop_flag_b, drop_count_b); end
    checks++; if (ib.out_valid !== 3'b000) begin errors++; $display("FAIL drop_many_no_valid: got %b expected 000", ib.out_valid); end
    ib.in_valid = 1'b1; clear_b = 1'b1;
    step();
    ib.in_valid = 1'b0; clear_b = 1'b0;
    checks++; if (drop_flag_b !== 1'b0 || drop_count_b !== 8'd0) begin errors++; $display("FAIL drop_clear_priority: got %b/%0d expected 0/0", drop_flag_b, drop_count_b); end
    ib.in_valid = 1'b1;
    step();
    ib.in_valid = 1'b0;
    checks++; if (drop_flag_b !== 1'b1 || drop_count_b !== 8'd1) begin errors++; $display("FAIL drop_after_clear: got %b/%0d expected 1/1", drop_flag_b, drop_count_b); end
  endtask

  task automatic test_zero_idle();
    ia.out_ready = 4'b1111; ib.out_ready = 3'b111;
    ia.Data_in = 8'h5C; ia.sel = 2'd0; ia.in_valid = 1'b1;
    ib.Data_in = 8'h5C; ib.sel = 2'd0; ib.in_valid = 1'b1;
    step();
    ia.in_valid = 1'b0; ib.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 4'b0001 || ia.Data_out !== 32'h0000_005C) begin errors++; $display("FAIL zi_load_a: got %b/%h expected 0001/0000005c", ia.out_valid, ia.Data_out); end
    checks++; if (ib.out_valid !== 3'b001 || ib.Data_out !== 24'h00_005C) begin errors++; $display("FAIL zi_load_b: got %b/%h expected 001/00005c", ib.out_valid, ib.Data_out); end
    step();
    checks++; if (ia.out_valid !== 4'b0000 || ia.Data_out !== 32'h0) begin errors++; $display("FAIL zi_idle_zero_a: got %b/%h expected 0000/00000000", ia.out_valid, ia.Data_out); end
    checks++; if (ib.out_valid !== 3'b000 || ib.Data_out !== 24'h00_005C) begin errors++; $display("FAIL zi_hold_b: got %b/%h expected 000/00005c", ib.out_valid, ib.Data_out); end
  endtask

  task automatic test_idle_x();
    ia.in_valid = 1'b0; ia.sel = 'x; ia.Data_in = 'x;
    repeat (3) step();
    checks++; if (ia.out_valid !== 4'b0000 || ia.Data_out !== 32'h0) begin errors++; $display("FAIL idle_x_state: got %b/%h expected 0000/00000000", ia.out_valid, ia.Data_out); end
    checks++; if (drop_flag_a !== 1'b0 || drop_count_a !== 8'd0) begin errors++; $display("FAIL idle_x_drop: got %b/%0d expected 0/0", drop_flag_a, drop_count_a); end
    ia.sel = '0; ia.Data_in = '0;
  endtask

  task automatic test_async_reset();
    ia.out_ready = '0; ib.out_ready = '0;
    ia.Data_in = 8'h10; ia.sel = 2'd0; ia.in_valid = 1'b1;
    ib.Data_in = 8'h10; ib.sel = 2'd0; ib.in_valid = 1'b1;
    step();
    ia.Data_in = 8'h30; ia.sel = 2'd2;
    ib.Data_in = 8'h30; ib.sel = 2'd2;
    step();
    ia.in_valid = 1'b0;
    ib.Data_in = 8'h77; ib.sel = 2'd3;
    step();
    ib.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 4'b0101 || ia.Data_out !== 32'h0030_0010) begin errors++; $display("FAIL ar_full_a: got %b/%h expected 0101/00300010", ia.out_valid, ia.Data_out); end
    checks++; if (ib.out_valid !== 3'b101 || ib.Data_out !== 24'h30_0010) begin errors++; $display("FAIL ar_full_b: got %b/%h expected 101/300010", ib.out_valid, ib.Data_out); end
    checks++; if (drop_count_b !== 8'd2) begin errors++; $display("FAIL ar_pre_count: got %0d expected 2", drop_count_b); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 4'b0000 || ia.Data_out !== 32'h0) begin errors++; $display("FAIL ar_clear_a: got %b/%h expected 0000/00000000", ia.out_valid, ia.Data_out); end
    checks++; if (ib.out_valid !== 3'b000 || ib.Data_out !== 24'h0) begin errors++; $display("FAIL ar_clear_b: got %b/%h expected 000/000000", ib.out_valid, ib.Data_out); end
    checks++; if (drop_flag_b !== 1'b0 || drop_count_b !== 8'd0) begin errors++; $display("FAIL ar_clear_drop: got %b/%0d expected 0/0", drop_flag_b, drop_count_b); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (ia.out_valid !== 4'b0000 || ib.out_valid !== 3'b000) begin errors++; $display("FAIL ar_after_release: got %b/%b expected 0000/000", ia.out_valid, ib.out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_back_to_back();
    test_drop();
    test_zero_idle();
    test_idle_x();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_stream_nch.md
Name: demux_stream_nch

Overview:
- Parametrised successor of the combinational 1-to-4 demultiplexer: routes one input word stream to NUM_CH output channels.
- Each output channel has a one-entry registered slot and a valid/ready handshake, so a stalled consumer back-pressures only the words addressed to it.
- Words addressed to a nonexistent channel are dropped and counted.
- Used between the multicycle datapath and peripheral/register-bank consumers that cannot always accept data in the cycle it is produced.

Parameters:
- WORD_LENGTH, 8, data word width in bits.
- NUM_CH, 4, number of output channels; range 2..16, need not be a power of 2.
- SEL_WIDTH, 2, select width; must satisfy 2^SEL_WIDTH >= NUM_CH.
- ZERO_IDLE, 1, 1: a channel's data output reads 0 while its valid is low (legacy demux behaviour); 0: it holds the last word.
- CNT_WIDTH, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Data_in  input  WORD_LENGTH  input word.
- sel  input  SEL_WIDTH  destination channel of Data_in.
- in_valid  input  1  Data_in/sel valid.
- in_ready  output  1  block accepts the word this cycle.
- Data_out  output  NUM_CH*WORD_LENGTH  packed channel data; channel k occupies bits [k*WORD_LENGTH +: WORD_LENGTH].
- out_valid  output  NUM_CH  per-channel slot holds a word.
- out_ready  input  NUM_CH  per-channel consumer accepts.
- clear_drop  input  1  synchronous clear of drop_count and drop_flag.
- drop_flag  output  1  sticky: at least one out-of-range word dropped.
- drop_count  output  CNT_WIDTH  saturating count of dropped words.

Behaviour:
- Reset (reset=0, asynchronous): all out_valid=0, all slot data=0, drop_flag=0, drop_count=0. Reset takes effect mid-transfer and discards any held words.
- in_ready is combinational:
  - sel < NUM_CH: in_ready = !out_valid[sel] || out_ready[sel].
  - sel >= NUM_CH: in_ready = 1.
  - in_ready depends on sel and must not depend on in_valid.
- Accept = in_valid && in_ready at a rising edge.
- Accept with sel < NUM_CH: slot[sel] <= Data_in and out_valid[sel] <= 1. Latency is 1 cycle: the word is visible on Data_out/out_valid in the cycle after acceptance.
- Drain: if out_valid[k] && out_ready[k] at an edge and channel k is not loaded that edge, out_valid[k] <= 0.
  - Simultaneous drain and load on the same channel: the new word replaces the old one and out_valid stays 1, giving full throughput of 1 word/cycle per channel.
- Channels are independent. A full channel with out_ready low stalls only inputs addressed to it, and other channels continue to drain.
- Only one channel can be loaded per cycle.
- Accept with sel >= NUM_CH:
  - The word is discarded and no out_valid changes.
  - drop_flag <= 1.
  - drop_count increments, saturating at 2^CNT_WIDTH-1 (no wrap).
- clear_drop=1: drop_flag <= 0 and drop_count <= 0.
  - If a drop happens in the same cycle, clear has priority and the result is flag=0, count=0.
- Data_out channel k:
  - ZERO_IDLE=1: output is slot[k] when out_valid[k] is 1, else 0.
  - ZERO_IDLE=0: output is slot[k] always.
- Slot data does not change while out_valid[k]=1 && out_ready[k]=0, because no load is possible then.
- in_valid=0: no state change other than drains.
- X on sel while in_valid=0 must not corrupt state.

Test Plan:
- Reset, then NUM_CH=4 with all out_ready=1: send 0xA5 with sel=2 -> next cycle out_valid=4'b0100 and Data_out[23:16]=0xA5, with all other bytes 0. One cycle later out_valid=0.
- Back-pressure: out_ready[1]=0, send 0x11 with sel=1, then 0x22 with sel=1 -> in_ready=0 for the second word, slot 1 holds 0x11. Meanwhile 0x33 with sel=3 is accepted and drains. Raise out_ready[1] -> 0x11 drains, then 0x22 is accepted and appears.
- Full throughput: out_ready[0]=1 held, stream 0x01..0x08 with sel=0 on consecutive cycles -> in_ready stays 1 and Data_out[7:0] shows 0x01..0x08 on successive cycles, one cycle delayed.
- Out of range with NUM_CH=3, SEL_WIDTH=2: send 0x77 with sel=3 -> in_ready=1, no out_valid set, drop_flag=1, drop_count=1. Repeat 300 times with CNT_WIDTH=8 -> drop_count=255. Pulse clear_drop together with another drop -> drop_flag=0, drop_count=0.
- ZERO_IDLE=0: after channel 0 drains 0x5C, Data_out[7:0] stays 0x5C with out_valid[0]=0. With ZERO_IDLE=1 it reads 0x00.
- Asynchronous reset asserted mid-cycle while channels 0 and 2 are full and stalled -> out_valid=0, Data_out=0 and drop_count=0 immediately, without waiting for a clock edge.
